// File: rtl/tcam_lookup_sched_pkg.sv
// Shared types and defaults for the TCAM lookup scheduler.
// Holds the FSM state encoding and the lowest-index hitline encoder.
package tcam_sched_pkg;

  localparam int NUM_REQ_DEF      = 4;
  localparam int ID_WIDTH_DEF     = 4;
  localparam int WEIGHT_WIDTH_DEF = 4;
  localparam int ADDR_WIDTH_DEF   = 4;
  localparam int BITS_DEF         = ID_WIDTH_DEF + WEIGHT_WIDTH_DEF;
  localparam int WORDS_DEF        = 16;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    FLUSH,
    COMPARE,
    READ,
    RESP
  } state_t;

  // Scans from the top down so the lowest set bit is the last one written.
  function automatic logic [ADDR_WIDTH_DEF-1:0] lowest_hit_index(input logic [WORDS_DEF-1:0] hl);
    lowest_hit_index = '0;
    for (int i = WORDS_DEF - 1; i >= 0; i--) begin
      if (hl[i]) lowest_hit_index = i[ADDR_WIDTH_DEF-1:0];
    end
  endfunction

endpackage

// File: rtl/tcam_lookup_sched_if.sv
// Bundles the lookup, response, programming and TCAM macro buses of the scheduler.
// slave = scheduler side, master = requesters/programming agent/macro side.
interface tcam_lookup_sched_if #(
  parameter int NUM_REQ      = 4,
  parameter int ID_WIDTH     = 4,
  parameter int WEIGHT_WIDTH = 4,
  parameter int ADDR_WIDTH   = 4,
  parameter int BITS         = 8,
  parameter int WORDS        = 16
);
  localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]          lk_valid;
  logic [NUM_REQ-1:0]          lk_ready;
  logic [NUM_REQ*ID_WIDTH-1:0] lk_id;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [TAG_W-1:0]        rsp_tag;
  logic                    rsp_hit;
  logic [ID_WIDTH-1:0]     rsp_dst;
  logic [WEIGHT_WIDTH-1:0] rsp_weight;

  logic                  cfg_valid;
  logic                  cfg_ready;
  logic                  cfg_flush;
  logic [ADDR_WIDTH-1:0] cfg_addr;
  logic [BITS-1:0]       cfg_data;
  logic [BITS-1:0]       cfg_mask;

  logic                  tcam_cs, tcam_wr, tcam_cmp, tcam_rd, tcam_flush, tcam_vbi;
  logic [ADDR_WIDTH-1:0] tcam_addr;
  logic [BITS-1:0]       tcam_di;
  logic [BITS-1:0]       tcam_mskb;
  logic [BITS-1:0]       tcam_do;
  logic                  tcam_hit;
  logic [WORDS-1:0]      tcam_hitline;

  modport slave (
    input  lk_valid, lk_id, rsp_ready,
    input  cfg_valid, cfg_flush, cfg_addr, cfg_data, cfg_mask,
    input  tcam_do, tcam_hit, tcam_hitline,
    output lk_ready, rsp_valid, rsp_tag, rsp_hit, rsp_dst, rsp_weight, cfg_ready,
    output tcam_cs, tcam_wr, tcam_cmp, tcam_rd, tcam_flush, tcam_vbi,
    output tcam_addr, tcam_di, tcam_mskb
  );

  modport master (
    output lk_valid, lk_id, rsp_ready,
    output cfg_valid, cfg_flush, cfg_addr, cfg_data, cfg_mask,
    output tcam_do, tcam_hit, tcam_hitline,
    input  lk_ready, rsp_valid, rsp_tag, rsp_hit, rsp_dst, rsp_weight, cfg_ready,
    input  tcam_cs, tcam_wr, tcam_cmp, tcam_rd, tcam_flush, tcam_vbi,
    input  tcam_addr, tcam_di, tcam_mskb
  );

endinterface

// File: rtl/tcam_lookup_sched_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from the pointer.
// Pointer moves past the granted requester only when advance is strobed.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any_gnt
);

  logic [IW-1:0] ptr_q;

  always_comb begin
    int c;
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    c       = 0;
    for (int i = 0; i < N; i++) begin
      c = (int'(ptr_q) + i) % N;
      if (!any_gnt && req[c]) begin
        any_gnt = 1'b1;
        gnt_idx = c[IW-1:0];
        gnt[c]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/tcam_lookup_sched.sv
// Time-shares one TCAM macro between round-robin lookups and a priority programming port.
// Lookup: grant T, compare T+1, encode/read T+2, response T+3 held until rsp_ready.
module tcam_lookup_sched
  import tcam_sched_pkg::*;
#(
  parameter int NUM_REQ      = NUM_REQ_DEF,
  parameter int ID_WIDTH     = ID_WIDTH_DEF,
  parameter int WEIGHT_WIDTH = WEIGHT_WIDTH_DEF,
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int BITS         = BITS_DEF,
  parameter int WORDS        = WORDS_DEF
) (
  input logic               clk,
  input logic               rst_n,
  tcam_lookup_sched_if.slave bus
);

  localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q;
  logic [TAG_W-1:0]      tag_q;
  logic                  hit_q;
  logic                  rsp_first_q;
  logic [BITS-1:0]       do_q;
  logic [BITS-1:0]       rsp_data;
  logic [ADDR_WIDTH-1:0] cfg_addr_q;
  logic [BITS-1:0]       cfg_data_q, cfg_mask_q;
  logic [WORDS-1:0]      hitline;
  logic [ADDR_WIDTH-1:0] hit_idx;

  logic [NUM_REQ-1:0]    arb_req, arb_gnt;
  logic [TAG_W-1:0]      arb_idx;
  logic                  arb_any;

  // Lookups are only offered to the arbiter when config is not claiming the macro.
  assign arb_req = bus.lk_valid & {NUM_REQ{rst_n && (state_q == IDLE) && !bus.cfg_valid}};

  rr_arbiter #(.N(NUM_REQ), .IW(TAG_W)) u_rr_arbiter (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (arb_req),
    .advance (arb_any),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any_gnt (arb_any)
  );

  assign hitline = bus.tcam_hitline;
  assign hit_idx = lowest_hit_index(hitline);

  // DO is live only in the first response cycle; afterwards the captured copy is shown.
  assign rsp_data = rsp_first_q ? bus.tcam_do : do_q;

  always_comb begin
    state_d        = state_q;
    bus.lk_ready   = '0;
    bus.cfg_ready  = 1'b0;
    bus.rsp_valid  = 1'b0;
    bus.rsp_tag    = '0;
    bus.rsp_hit    = 1'b0;
    bus.rsp_dst    = '0;
    bus.rsp_weight = '0;
    bus.tcam_cs    = 1'b0;
    bus.tcam_wr    = 1'b0;
    bus.tcam_cmp   = 1'b0;
    bus.tcam_rd    = 1'b0;
    bus.tcam_flush = 1'b0;
    bus.tcam_vbi   = 1'b0;
    bus.tcam_addr  = '0;
    bus.tcam_di    = '0;
    bus.tcam_mskb  = '0;
    if (rst_n) begin
      unique case (state_q)
        IDLE: begin
          if (bus.cfg_valid) begin
            bus.cfg_ready = 1'b1;
            state_d       = bus.cfg_flush ? FLUSH : WRITE;
          end else if (arb_any) begin
            bus.lk_ready = arb_gnt;
            state_d      = COMPARE;
          end
        end
        WRITE: begin
          bus.tcam_cs   = 1'b1;
          bus.tcam_wr   = 1'b1;
          bus.tcam_vbi  = 1'b1;
          bus.tcam_addr = cfg_addr_q;
          bus.tcam_di   = cfg_data_q;
          bus.tcam_mskb = cfg_mask_q;
          state_d       = IDLE;
        end
        FLUSH: begin
          bus.tcam_cs    = 1'b1;
          bus.tcam_flush = 1'b1;
          state_d        = IDLE;
        end
        COMPARE: begin
          bus.tcam_cs   = 1'b1;
          bus.tcam_cmp  = 1'b1;
          bus.tcam_di   = {id_q, {ID_WIDTH{1'b0}}};
          bus.tcam_mskb = {{ID_WIDTH{1'b1}}, {ID_WIDTH{1'b0}}};
          state_d       = READ;
        end
        READ: begin
          bus.tcam_addr = hit_idx;
          bus.tcam_cs   = bus.tcam_hit;
          bus.tcam_rd   = bus.tcam_hit;
          state_d       = RESP;
        end
        RESP: begin
          bus.rsp_valid  = 1'b1;
          bus.rsp_tag    = tag_q;
          bus.rsp_hit    = hit_q;
          bus.rsp_dst    = hit_q ? rsp_data[ID_WIDTH-1:0] : '0;
          bus.rsp_weight = hit_q ? rsp_data[BITS-1:ID_WIDTH] : '0;
          if (bus.rsp_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      id_q        <= '0;
      tag_q       <= '0;
      hit_q       <= 1'b0;
      rsp_first_q <= 1'b0;
      do_q        <= '0;
      cfg_addr_q  <= '0;
      cfg_data_q  <= '0;
      cfg_mask_q  <= '0;
    end else begin
      state_q     <= state_d;
      rsp_first_q <= (state_q == READ);
      if (state_q == IDLE && bus.cfg_valid) begin
        cfg_addr_q <= bus.cfg_addr;
        cfg_data_q <= bus.cfg_data;
        cfg_mask_q <= bus.cfg_mask;
      end
      if (arb_any) begin
        id_q  <= bus.lk_id[arb_idx*ID_WIDTH +: ID_WIDTH];
        tag_q <= arb_idx;
      end
      if (state_q == READ) hit_q <= bus.tcam_hit;
      if (rsp_first_q) do_q <= bus.tcam_do;
    end
  end

endmodule

// File: tb/tb_tcam_lookup_sched.sv
// Bench for tcam_lookup_sched with a behavioural 16x8 TCAM macro and a response scoreboard.
// Macro model matches the compare key (DI upper field) against each valid entry's dst field.
module tb_tcam_lookup_sched;
  import tcam_sched_pkg::*;

  localparam int NR = 4, IW = 4, B = 8, W = 16;

  typedef struct {
    logic [1:0]    tag;
    logic          hit;
    logic [IW-1:0] dst;
    logic [3:0]    wt;
    logic [3:0]    addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tcam_lookup_sched_if bus ();

  tcam_lookup_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- macro model ----------------
  logic [B-1:0] mem   [W];
  logic [B-1:0] emask [W];
  logic [W-1:0] evld = '0;

  function automatic logic [W-1:0] macro_match(input logic [B-1:0] key, input logic [B-1:0] km);
    macro_match = '0;
    for (int i = 0; i < W; i++)
      macro_match[i] = evld[i] &&
        (((mem[i][IW-1:0] ^ key[B-1:IW]) & km[B-1:IW] & emask[i][B-1:IW]) == '0);
  endfunction

  always @(posedge clk) begin
    if (bus.tcam_cs && bus.tcam_wr) begin
      mem[bus.tcam_addr]   <= bus.tcam_di;
      emask[bus.tcam_addr] <= bus.tcam_mskb;
      evld[bus.tcam_addr]  <= bus.tcam_vbi;
    end
    if (bus.tcam_cs && bus.tcam_flush) evld <= '0;
    if (bus.tcam_cs && bus.tcam_cmp) begin
      bus.tcam_hitline <= macro_match(bus.tcam_di, bus.tcam_mskb);
      bus.tcam_hit     <= |macro_match(bus.tcam_di, bus.tcam_mskb);
    end
    bus.tcam_do <= (bus.tcam_cs && bus.tcam_rd) ? mem[bus.tcam_addr] : 8'hA5;
  end

  // ---------------- reference model / scoreboard ----------------
  logic [B-1:0] ref_data [W];
  bit           ref_vld  [W];
  exp_t         sbq[$];
  int           rr_ptr;
  int           n_pass, n_tot;

  function automatic int model_grant(input logic [NR-1:0] m);
    model_grant = -1;
    for (int i = NR - 1; i >= 0; i--)
      if (m[(rr_ptr + i) % NR]) model_grant = (rr_ptr + i) % NR;
  endfunction

  function automatic exp_t ref_lookup(input int tag, input logic [IW-1:0] id);
    exp_t e;
    e.tag = tag[1:0]; e.hit = 1'b0; e.dst = '0; e.wt = '0; e.addr = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (ref_vld[i] && ref_data[i][IW-1:0] == id) begin
        e.hit = 1'b1; e.dst = ref_data[i][IW-1:0]; e.wt = ref_data[i][B-1:IW]; e.addr = i[3:0];
      end
    end
    return e;
  endfunction

  task automatic cfg_cmd(input bit fl, input logic [3:0] a, input logic [7:0] d,
                         input logic [7:0] m, output bit ok);
    @(negedge clk);
    bus.cfg_valid = 1'b1; bus.cfg_flush = fl; bus.cfg_addr = a; bus.cfg_data = d; bus.cfg_mask = m;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (bus.cfg_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok && fl) for (int i = 0; i < W; i++) ref_vld[i] = 1'b0;
    if (ok && !fl) begin ref_data[a] = d; ref_vld[a] = 1'b1; end
    @(negedge clk);
    bus.cfg_valid = 1'b0;
  endtask

  task automatic issue(input logic [NR-1:0] vm, input logic [NR*IW-1:0] ids,
                       output int g, output int eg);
    @(negedge clk);
    bus.lk_valid = vm; bus.lk_id = ids;
    eg = model_grant(vm);
    g  = -1;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (|bus.lk_ready) begin
        for (int i = 0; i < NR; i++) if (bus.lk_ready[i]) g = i;
        break;
      end
      @(negedge clk);
    end
    sbq.push_back(ref_lookup(eg, ids[eg*IW +: IW]));
    rr_ptr = (eg + 1) % NR;
  endtask

  task automatic wait_rsp(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (bus.rsp_valid) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.lk_valid = '1; bus.lk_id = '0; bus.rsp_ready = 1'b1; bus.cfg_valid = 1'b1;
    bus.cfg_flush = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0; bus.cfg_mask = '0;
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    n_tot++;
    if ({bus.lk_ready, bus.cfg_ready, bus.rsp_valid, bus.rsp_hit, bus.rsp_tag, bus.rsp_dst, bus.rsp_weight} !== '0)
      $display("FAIL reset_hs: got lk_ready=%b cfg_ready=%b rsp_valid=%b want all 0",
               bus.lk_ready, bus.cfg_ready, bus.rsp_valid);
    else n_pass++;
    n_tot++;
    if ({bus.tcam_cs, bus.tcam_wr, bus.tcam_cmp, bus.tcam_rd, bus.tcam_flush, bus.tcam_vbi,
         bus.tcam_addr, bus.tcam_di, bus.tcam_mskb} !== '0)
      $display("FAIL reset_tcam: got cs=%b wr=%b cmp=%b rd=%b want 0", bus.tcam_cs, bus.tcam_wr,
               bus.tcam_cmp, bus.tcam_rd);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1; bus.lk_valid = '0; bus.cfg_valid = 1'b0; rr_ptr = 0;
    #1;
    n_tot++;
    if ({bus.lk_ready, bus.rsp_valid, bus.tcam_cs} !== '0)
      $display("FAIL idle_quiet: got lk_ready=%b rsp_valid=%b cs=%b want 0", bus.lk_ready, bus.rsp_valid, bus.tcam_cs);
    else n_pass++;
  endtask

  task automatic test_write_lookup();
    bit ok; int g, eg; exp_t e;
    cfg_cmd(1'b0, 4'd3, 8'h59, 8'hF0, ok);
    n_tot++; if (ok !== 1'b1) $display("FAIL wr3_accept: got %b want 1", ok); else n_pass++;
    issue(4'b0001, 16'h0009, g, eg);
    n_tot++; if (g != eg) $display("FAIL wl_grant: got %0d want %0d", g, eg); else n_pass++;
    @(negedge clk); bus.lk_valid = '0; #1;
    n_tot++;
    if ({bus.tcam_cs, bus.tcam_cmp, bus.tcam_rd, bus.tcam_wr, bus.tcam_di, bus.tcam_mskb} !== {4'b1100, 8'h90, 8'hF0})
      $display("FAIL wl_compare: got cs/cmp/rd/wr=%b%b%b%b di=%h mskb=%h want 1100 90 f0",
               bus.tcam_cs, bus.tcam_cmp, bus.tcam_rd, bus.tcam_wr, bus.tcam_di, bus.tcam_mskb);
    else n_pass++;
    @(negedge clk); #1;
    n_tot++;
    if ({bus.tcam_cs, bus.tcam_rd, bus.tcam_cmp, bus.tcam_addr, bus.rsp_valid} !== {3'b110, 4'd3, 1'b0})
      $display("FAIL wl_read: got cs=%b rd=%b cmp=%b addr=%0d rsp_valid=%b want 1 1 0 3 0",
               bus.tcam_cs, bus.tcam_rd, bus.tcam_cmp, bus.tcam_addr, bus.rsp_valid);
    else n_pass++;
    @(negedge clk); #1;
    e = sbq.pop_front();
    n_tot++;
    if ({bus.rsp_valid, bus.rsp_tag, bus.rsp_hit, bus.rsp_dst, bus.rsp_weight} !== {1'b1, e.tag, e.hit, e.dst, e.wt})
      $display("FAIL wl_rsp: got v=%b tag=%0d hit=%b dst=%h wt=%h want 1 %0d %b %h %h", bus.rsp_valid,
               bus.rsp_tag, bus.rsp_hit, bus.rsp_dst, bus.rsp_weight, e.tag, e.hit, e.dst, e.wt);
    else n_pass++;
    @(negedge clk); #1;
    n_tot++; if (bus.rsp_valid !== 1'b0) $display("FAIL wl_rsp_drop: got %b want 0", bus.rsp_valid); else n_pass++;
  endtask

  task automatic test_lookup(input string nm, input logic [NR-1:0] vm, input logic [NR*IW-1:0] ids);
    int g, eg; exp_t e;
    issue(vm, ids, g, eg);
    n_tot++; if (g != eg) $display("FAIL %s_grant: got %0d want %0d", nm, g, eg); else n_pass++;
    @(negedge clk); bus.lk_valid = '0;
    @(negedge clk); #1;
    e = sbq[0];
    n_tot++;
    if ({bus.tcam_rd, bus.tcam_cs, bus.tcam_addr} !== {e.hit, e.hit, e.addr})
      $display("FAIL %s_read: got rd=%b cs=%b addr=%0d want %b %b %0d", nm, bus.tcam_rd, bus.tcam_cs,
               bus.tcam_addr, e.hit, e.hit, e.addr);
    else n_pass++;
    @(negedge clk); #1;
    e = sbq.pop_front();
    n_tot++;
    if ({bus.rsp_valid, bus.rsp_tag, bus.rsp_hit, bus.rsp_dst, bus.rsp_weight} !== {1'b1, e.tag, e.hit, e.dst, e.wt})
      $display("FAIL %s_rsp: got v=%b tag=%0d hit=%b dst=%h wt=%h want 1 %0d %b %h %h", nm, bus.rsp_valid,
               bus.rsp_tag, bus.rsp_hit, bus.rsp_dst, bus.rsp_weight, e.tag, e.hit, e.dst, e.wt);
    else n_pass++;
  endtask

  task automatic test_multi_hit();
    bit ok1, ok2;
    cfg_cmd(1'b0, 4'd2, 8'h14, 8'hF0, ok1);
    cfg_cmd(1'b0, 4'd7, 8'h64, 8'hF0, ok2);
    n_tot++; if ({ok1, ok2} !== 2'b11) $display("FAIL mh_cfg: got %b%b want 11", ok1, ok2); else n_pass++;
    test_lookup("multi_hit", 4'b0010, 16'h0040);
  endtask

  task automatic test_cfg_priority();
    bit ok; int eg; exp_t e;
    logic [1+2+1+4+4-1:0] snap;
    @(negedge clk);
    bus.cfg_valid = 1'b1; bus.cfg_flush = 1'b0; bus.cfg_addr = 4'd5; bus.cfg_data = 8'h3B; bus.cfg_mask = 8'hF0;
    bus.lk_valid = 4'b0010; bus.lk_id = 16'h00B0;
    #1;
    n_tot++;
    if ({bus.cfg_ready, bus.lk_ready} !== 5'b10000)
      $display("FAIL prio_idle: got cfg_ready=%b lk_ready=%b want 1 0000", bus.cfg_ready, bus.lk_ready);
    else n_pass++;
    ref_data[5] = 8'h3B; ref_vld[5] = 1'b1;
    @(negedge clk); bus.cfg_valid = 1'b0; #1;
    n_tot++;
    if ({bus.tcam_cs, bus.tcam_wr, bus.tcam_vbi, bus.tcam_addr, bus.tcam_di, bus.tcam_mskb, bus.lk_ready} !==
        {3'b111, 4'd5, 8'h3B, 8'hF0, 4'b0000})
      $display("FAIL prio_write: got cs/wr/vbi=%b%b%b addr=%0d di=%h mskb=%h lk_ready=%b want 111 5 3b f0 0000",
               bus.tcam_cs, bus.tcam_wr, bus.tcam_vbi, bus.tcam_addr, bus.tcam_di, bus.tcam_mskb, bus.lk_ready);
    else n_pass++;
    @(negedge clk); #1;
    eg = model_grant(4'b0010);
    n_tot++;
    if (bus.lk_ready !== 4'(1 << eg)) $display("FAIL prio_grant: got %b want %b", bus.lk_ready, 4'(1 << eg));
    else n_pass++;
    sbq.push_back(ref_lookup(eg, 4'hB)); rr_ptr = (eg + 1) % NR;
    @(negedge clk); bus.lk_valid = 4'b0001; bus.lk_id = 16'h0009; bus.rsp_ready = 1'b0; #1;
    wait_rsp(10, ok);
    n_tot++; if (ok !== 1'b1) $display("FAIL prio_rsp_timeout: got %b want 1", ok); else n_pass++;
    e = sbq.pop_front();
    snap = {bus.rsp_valid, bus.rsp_tag, bus.rsp_hit, bus.rsp_dst, bus.rsp_weight};
    n_tot++;
    if (snap !== {1'b1, e.tag, e.hit, e.dst, e.wt})
      $display("FAIL prio_rsp: got %h want %h", snap, {1'b1, e.tag, e.hit, e.dst, e.wt});
    else n_pass++;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      n_tot++;
      if ({bus.rsp_valid, bus.rsp_tag, bus.rsp_hit, bus.rsp_dst, bus.rsp_weight, bus.lk_ready} !== {snap, 4'b0000})
        $display("FAIL stall_hold_%0d: got rsp=%h lk_ready=%b want %h 0000", k,
                 {bus.rsp_valid, bus.rsp_tag, bus.rsp_hit, bus.rsp_dst, bus.rsp_weight}, bus.lk_ready, snap);
      else n_pass++;
    end
    @(negedge clk); bus.rsp_ready = 1'b1; bus.lk_valid = '0;
    @(negedge clk); #1;
    n_tot++; if (bus.rsp_valid !== 1'b0) $display("FAIL prio_release: got %b want 0", bus.rsp_valid); else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    bit ok; int g, eg; exp_t e;
    issue(4'b0100, 16'h0900, g, eg);
    n_tot++; if (g != eg) $display("FAIL rr_pre_grant: got %0d want %0d", g, eg); else n_pass++;
    @(negedge clk); bus.lk_valid = '0;
    @(negedge clk); rst_n = 1'b0;
    void'(sbq.pop_front());
    rr_ptr = 0;
    @(negedge clk); bus.lk_valid = 4'b1100; bus.lk_id = 16'h4900; #1;
    n_tot++;
    if ({bus.lk_ready, bus.cfg_ready, bus.rsp_valid, bus.tcam_cs, bus.tcam_rd, bus.tcam_cmp, bus.tcam_addr} !== '0)
      $display("FAIL rr_reset_out: got lk_ready=%b rsp_valid=%b cs=%b rd=%b addr=%0d want 0",
               bus.lk_ready, bus.rsp_valid, bus.tcam_cs, bus.tcam_rd, bus.tcam_addr);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1; #1;
    eg = model_grant(4'b1100);
    n_tot++;
    if (bus.lk_ready !== 4'(1 << eg)) $display("FAIL rr_after_reset: got %b want %b", bus.lk_ready, 4'(1 << eg));
    else n_pass++;
    sbq.push_back(ref_lookup(eg, 4'h9)); rr_ptr = (eg + 1) % NR;
    @(negedge clk); bus.lk_valid = '0; #1;
    wait_rsp(10, ok);
    e = sbq.pop_front();
    n_tot++;
    if ({ok, bus.rsp_tag, bus.rsp_hit, bus.rsp_dst, bus.rsp_weight} !== {1'b1, e.tag, e.hit, e.dst, e.wt})
      $display("FAIL rr_rsp: got ok=%b tag=%0d hit=%b dst=%h wt=%h want 1 %0d %b %h %h", ok, bus.rsp_tag,
               bus.rsp_hit, bus.rsp_dst, bus.rsp_weight, e.tag, e.hit, e.dst, e.wt);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int grants, rsps, last, eg;
    exp_t e;
    logic [NR*IW-1:0] ids;
    ids = 16'h4E49;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; rr_ptr = 0;
    bus.lk_id = ids; bus.lk_valid = '1;
    grants = 0; rsps = 0; last = 0;
    for (int cyc = 0; cyc < 80 && rsps < 5; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (grants == 5) bus.lk_valid = '0;
      #1;
      if (|bus.lk_ready) begin
        eg = model_grant(bus.lk_valid);
        n_tot++;
        if (bus.lk_ready !== 4'(1 << eg))
          $display("FAIL b2b_grant_%0d: got %b want %b", grants, bus.lk_ready, 4'(1 << eg));
        else n_pass++;
        if (grants > 0) begin
          n_tot++;
          if (cyc - last != 4) $display("FAIL b2b_spacing_%0d: got %0d want 4", grants, cyc - last);
          else n_pass++;
        end
        sbq.push_back(ref_lookup(eg, ids[eg*IW +: IW]));
        rr_ptr = (eg + 1) % NR;
        last = cyc; grants++;
      end
      if (bus.rsp_valid) begin
        n_tot++;
        if (sbq.size() == 0) begin
          $display("FAIL b2b_unexpected_rsp: got tag=%0d want none", bus.rsp_tag);
        end else begin
          e = sbq.pop_front();
          if ({bus.rsp_tag, bus.rsp_hit, bus.rsp_dst, bus.rsp_weight} !== {e.tag, e.hit, e.dst, e.wt})
            $display("FAIL b2b_rsp_%0d: got tag=%0d hit=%b dst=%h wt=%h want %0d %b %h %h", rsps, bus.rsp_tag,
                     bus.rsp_hit, bus.rsp_dst, bus.rsp_weight, e.tag, e.hit, e.dst, e.wt);
          else n_pass++;
        end
        rsps++;
      end
    end
    n_tot++;
    if (grants != 5 || rsps != 5) $display("FAIL b2b_count: got grants=%0d rsps=%0d want 5 5", grants, rsps);
    else n_pass++;
  endtask

  task automatic test_flush();
    bit ok;
    cfg_cmd(1'b1, 4'd0, 8'h00, 8'h00, ok);
    #1;
    n_tot++;
    if ({ok, bus.tcam_cs, bus.tcam_flush, bus.tcam_wr, bus.tcam_vbi} !== 5'b11100)
      $display("FAIL flush_pulse: got ok=%b cs=%b flush=%b wr=%b vbi=%b want 1 1 1 0 0", ok, bus.tcam_cs,
               bus.tcam_flush, bus.tcam_wr, bus.tcam_vbi);
    else n_pass++;
    test_lookup("post_flush", 4'b0010, 16'h0090);
  endtask

  initial begin
    n_pass = 0; n_tot = 0; rr_ptr = 0;
    for (int i = 0; i < W; i++) begin ref_data[i] = '0; ref_vld[i] = 1'b0; end
    test_reset();
    test_write_lookup();
    test_multi_hit();
    test_lookup("miss", 4'b0100, 16'h0E00);
    test_cfg_priority();
    test_reset_mid_read();
    test_back_to_back();
    test_flush();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks", n_pass, n_tot);
    $fatal(1);
  end

endmodule
